// File: rtl/framebuffer_writer_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces for framebuffer_writer.
//
// pixel_stream_if : rasterizer -> framebuffer_writer pixel stream.
//   master (rasterizer) drives pixel_color, pixel_valid, pixel_x, pixel_y,
//   pixel_draw, frame_end; slave (writer) drives pixel_ready.
//
// fb_write_if     : framebuffer_writer -> memory write port.
//   master (writer) drives fb_wr_addr, fb_wr_data, fb_wr_valid;
//   slave (memory) drives fb_wr_ready.
// -----------------------------------------------------------------------------
interface pixel_stream_if;
    logic [7:0]  pixel_color;
    logic        pixel_valid;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        pixel_draw;
    logic        frame_end;
    logic        pixel_ready;

    modport master (
        output pixel_color, pixel_valid, pixel_x, pixel_y, pixel_draw, frame_end,
        input  pixel_ready
    );

    modport slave (
        input  pixel_color, pixel_valid, pixel_x, pixel_y, pixel_draw, frame_end,
        output pixel_ready
    );
endinterface

interface fb_write_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [7:0]        fb_wr_data;
    logic              fb_wr_valid;
    logic              fb_wr_ready;

    modport master (
        output fb_wr_addr, fb_wr_data, fb_wr_valid,
        input  fb_wr_ready
    );

    modport slave (
        input  fb_wr_addr, fb_wr_data, fb_wr_valid,
        output fb_wr_ready
    );
endinterface

// File: rtl/framebuffer_writer.sv
// -----------------------------------------------------------------------------
// framebuffer_writer
//
// Pixel sink behind the rasterizer. Each accepted pixel is clipped to the
// visible area and linearised into the back buffer of a double-buffered
// framebuffer; kept pixels pass through one register stage (S1) into a
// first-word-fall-through FIFO whose head drives a stallable memory write
// port. On frame_end the block stops accepting, drains S1 and the FIFO, then
// swaps front/back buffers with a one-cycle pulse.
//
// Ports:
//   clk           : single clock
//   reset         : asynchronous, active-high
//   pix           : pixel stream (slave modport), pixel_ready is our output
//   fb            : memory write port (master modport)
//   front_buffer  : buffer currently displayed (0 = lower half, 1 = upper half)
//   swap_pulse    : one-cycle pulse, coincident with a front_buffer toggle
//   busy          : S1 or FIFO occupied, or FSM not in RUN
//   clipped_count : saturating count of drawn pixels that fell off-screen
//   overflow      : sticky, pixel_valid seen while pixel_ready was low
// -----------------------------------------------------------------------------
module framebuffer_writer #(
    parameter int FB_WIDTH   = 320,
    parameter int FB_HEIGHT  = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 18
) (
    input  logic                clk,
    input  logic                reset,
    pixel_stream_if.slave       pix,
    fb_write_if.master          fb,
    output logic                front_buffer,
    output logic                swap_pulse,
    output logic                busy,
    output logic [15:0]         clipped_count,
    output logic                overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [31:0]      WIDTH_U   = 32'(FB_WIDTH);
    localparam logic [31:0]      HEIGHT_U  = 32'(FB_HEIGHT);
    localparam logic [31:0]      HALF_U    = 32'(FB_WIDTH * FB_HEIGHT);
    localparam logic [CNT_W:0]   DEPTH_U   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   pending, pending_next;

    // S1 register stage
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [7:0]        s1_data;

    // Write FIFO
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [7:0]        mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic              accept;
    logic              in_range;
    logic              keep;
    logic              push;
    logic              pop;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] pixel_addr;

    // -------------------------------------------------------------------------
    // Accept / clip / address
    // -------------------------------------------------------------------------
    // S1 is counted as occupied so that a pixel accepted now always finds a
    // FIFO slot one cycle later; S1 therefore never has to stall.
    assign occupancy       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
    assign pix.pixel_ready = (state == RUN) && (occupancy < DEPTH_U);

    assign accept   = pix.pixel_valid && pix.pixel_ready;
    assign in_range = (32'(pix.pixel_x) < WIDTH_U) && (32'(pix.pixel_y) < HEIGHT_U);
    assign keep     = pix.pixel_draw && in_range;

    // Writes go to the back buffer: upper half while lower half is displayed.
    // Full 32-bit arithmetic, then truncated to the port width.
    assign pixel_addr = ADDR_W'((front_buffer ? 32'd0 : HALF_U)
                              + 32'(pix.pixel_y) * WIDTH_U
                              + 32'(pix.pixel_x));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept && keep;
            if (accept) begin
                s1_addr <= pixel_addr;
                s1_data <= pix.pixel_color;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO (first-word-fall-through)
    // -------------------------------------------------------------------------
    assign push = s1_valid;
    assign pop  = fb.fb_wr_valid && fb.fb_wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: storage array has no reset; validity is tracked solely by
    // fifo_count, and the outputs are forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= s1_addr;
            mem_data[wr_ptr] <= s1_data;
        end
    end

    assign fb.fb_wr_valid = (fifo_count != '0);
    assign fb.fb_wr_addr  = fb.fb_wr_valid ? mem_addr[rd_ptr] : '0;
    assign fb.fb_wr_data  = fb.fb_wr_valid ? mem_data[rd_ptr] : '0;

    // -------------------------------------------------------------------------
    // Frame FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
        end
    end

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned (which would infer a latch).
    always_comb begin
        state_next   = state;
        pending_next = pending;
        case (state)
            RUN: begin
                // A latched end is consumed here; a fresh frame_end in the
                // same cycle collapses into the same drain.
                pending_next = 1'b0;
                if (pix.frame_end || pending) state_next = DRAIN;
            end
            DRAIN: begin
                if (pix.frame_end) pending_next = 1'b1;
                if (!s1_valid && (fifo_count == '0)) state_next = SWAP;
            end
            SWAP: begin
                if (pix.frame_end) pending_next = 1'b1;
                state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_buffer <= 1'b0;
            swap_pulse   <= 1'b0;
        end else begin
            swap_pulse <= (state == SWAP);
            if (state == SWAP) front_buffer <= ~front_buffer;
        end
    end

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clipped_count <= '0;
            overflow      <= 1'b0;
        end else begin
            if (accept && pix.pixel_draw && !in_range && (clipped_count != 16'hFFFF))
                clipped_count <= clipped_count + 16'd1;
            if (pix.pixel_valid && !pix.pixel_ready)
                overflow <= 1'b1;
        end
    end

    // Derived only from registered state, never from the pixel inputs.
    assign busy = s1_valid || (fifo_count != '0) || (state != RUN);

endmodule

// File: tb/tb_framebuffer_writer.sv
// -----------------------------------------------------------------------------
// Testbench for framebuffer_writer. Expected writes are pushed to a scoreboard
// queue when a kept pixel is accepted and popped by a monitor as the memory
// port accepts each write. Inputs change on the falling clock edge; the
// monitor samples shortly after it.
// -----------------------------------------------------------------------------
module tb_framebuffer_writer;

    localparam int W  = 320;
    localparam int H  = 240;
    localparam int D  = 16;
    localparam int AW = 18;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        front_buffer;
    logic        swap_pulse;
    logic        busy;
    logic [15:0] clipped_count;
    logic        overflow;

    pixel_stream_if           pix ();
    fb_write_if #(.ADDR_W(AW)) fb ();

    framebuffer_writer #(
        .FB_WIDTH   (W),
        .FB_HEIGHT  (H),
        .FIFO_DEPTH (D),
        .ADDR_W     (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pix           (pix),
        .fb            (fb),
        .front_buffer  (front_buffer),
        .swap_pulse    (swap_pulse),
        .busy          (busy),
        .clipped_count (clipped_count),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int   checks      = 0;
    int   failures    = 0;
    int   write_count = 0;
    int   swap_count  = 0;
    logic model_front = 1'b0;
    wr_t  sb [$];

    logic hold_pending = 1'b0;
    wr_t  hold_val;

    // Expected address: back buffer is the half not being displayed.
    function automatic logic [AW-1:0] exp_addr(input int x, input int y);
        int a;
        a = (model_front ? 0 : W * H) + y * W + x;
        return AW'(a);
    endfunction

    // Write monitor: scoreboard compare on every accepted write, plus
    // stability of address/data while a write is stalled.
    always @(negedge clk) begin
        wr_t got;
        wr_t e;
        #2;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            got = {fb.fb_wr_addr, fb.fb_wr_data};
            if (swap_pulse === 1'b1) swap_count++;
            if (hold_pending) begin
                checks++;
                if (fb.fb_wr_valid !== 1'b1 || got !== hold_val) begin
                    failures++;
                    $display("FAIL stall_stable: got valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                             fb.fb_wr_valid, got.addr, got.data, hold_val.addr, hold_val.data);
                end
            end
            if (fb.fb_wr_valid === 1'b1 && fb.fb_wr_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", got.addr, got.data);
                end else begin
                    e = sb.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                                 got.addr, got.data, e.addr, e.data);
                    end
                end
                write_count++;
                hold_pending = 1'b0;
            end else if (fb.fb_wr_valid === 1'b1) begin
                hold_pending = 1'b1;
                hold_val     = got;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        pix.pixel_valid = 1'b0;
        pix.pixel_color = 8'h00;
        pix.pixel_x     = 11'd0;
        pix.pixel_y     = 11'd0;
        pix.pixel_draw  = 1'b0;
        pix.frame_end   = 1'b0;
    endtask

    // Offer one pixel only when pixel_ready is high; returns one cycle later.
    task automatic send_pixel(input int x, input int y, input logic [7:0] c,
                              input logic draw, input logic fe);
        int budget = 200;
        while (pix.pixel_ready !== 1'b1 && budget > 0) begin
            pix.pixel_valid = 1'b0;
            pix.frame_end   = 1'b0;
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got pixel_ready=0 for 200 cycles, required 1 (x=%0d y=%0d)", x, y);
            return;
        end
        pix.pixel_valid = 1'b1;
        pix.pixel_color = c;
        pix.pixel_x     = 11'(x);
        pix.pixel_y     = 11'(y);
        pix.pixel_draw  = draw;
        pix.frame_end   = fe;
        if (draw && x < W && y < H) sb.push_back({exp_addr(x, y), c});
        @(negedge clk);
        pix.pixel_valid = 1'b0;
        pix.frame_end   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int budget = 500;
        while ((busy !== 1'b0 || sb.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin
            failures++;
            $display("FAIL %s_idle: got busy=%b pending_writes=%0d, required busy=0 pending_writes=0",
                     tag, busy, sb.size());
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        fb.fb_wr_ready = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++;
        if (pix.pixel_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got pixel_ready=%b busy=%b, required 1 0", pix.pixel_ready, busy);
        end
        checks++;
        if (fb.fb_wr_valid !== 1'b0 || fb.fb_wr_addr !== '0 || fb.fb_wr_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_wr_port: got valid=%b addr=%0d data=%h, required 0 0 00",
                     fb.fb_wr_valid, fb.fb_wr_addr, fb.fb_wr_data);
        end
        checks++;
        if (front_buffer !== 1'b0 || swap_pulse !== 1'b0 || clipped_count !== 16'd0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: got front=%b swap=%b clipped=%0d overflow=%b, required 0 0 0 0",
                     front_buffer, swap_pulse, clipped_count, overflow);
        end
    endtask

    task automatic test_single_pixel();
        send_pixel(3, 2, 8'hA5, 1'b1, 1'b0);
        // T+1: pixel sits in S1, no write yet
        checks++;
        if (fb.fb_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_t1: got fb_wr_valid=%b, required 0", fb.fb_wr_valid);
        end
        @(negedge clk);
        // T+2: FIFO head
        checks++;
        if (fb.fb_wr_valid !== 1'b1 || fb.fb_wr_addr !== 18'd77443 || fb.fb_wr_data !== 8'hA5) begin
            failures++;
            $display("FAIL single_t2: got valid=%b addr=%0d data=%h, required 1 77443 a5",
                     fb.fb_wr_valid, fb.fb_wr_addr, fb.fb_wr_data);
        end
        @(negedge clk);
        checks++;
        if (fb.fb_wr_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_t3: got fb_wr_valid=%b, required 0", fb.fb_wr_valid);
        end
        wait_idle("single");
    endtask

    task automatic test_clip();
        int wc0 = write_count;
        send_pixel(320, 0,   8'h01, 1'b1, 1'b0);
        send_pixel(0,   240, 8'h02, 1'b1, 1'b0);
        send_pixel(5,   5,   8'h03, 1'b0, 1'b0);
        send_pixel(319, 239, 8'h3C, 1'b1, 1'b0);
        wait_idle("clip");
        checks++;
        if (clipped_count !== 16'd2) begin
            failures++;
            $display("FAIL clip_count: got %0d, required 2", clipped_count);
        end
        checks++;
        if (write_count - wc0 != 1) begin
            failures++;
            $display("FAIL clip_writes: got %0d writes, required 1", write_count - wc0);
        end
    endtask

    task automatic test_backpressure();
        int   wc0       = write_count;
        logic all_ready = 1'b1;
        fb.fb_wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pix.pixel_ready !== 1'b1) all_ready = 1'b0;
            send_pixel(i, 10, 8'(8'h10 + i), 1'b1, 1'b0);
        end
        checks++;
        if (all_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_fill_ready: got pixel_ready low before 16 accepted, required high");
        end
        checks++;
        if (pix.pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full_ready: got pixel_ready=%b after 16 pixels, required 0", pix.pixel_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (pix.pixel_ready !== 1'b0 || fb.fb_wr_valid !== 1'b1 || fb.fb_wr_addr !== 18'd80000 ||
            fb.fb_wr_data !== 8'h10) begin
            failures++;
            $display("FAIL bp_head: got ready=%b valid=%b addr=%0d data=%h, required 0 1 80000 10",
                     pix.pixel_ready, fb.fb_wr_valid, fb.fb_wr_addr, fb.fb_wr_data);
        end
        fb.fb_wr_ready = 1'b1;
        for (int i = 16; i < 20; i++) send_pixel(i, 10, 8'(8'h10 + i), 1'b1, 1'b0);
        wait_idle("bp");
        checks++;
        if (write_count - wc0 != 20 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL bp_total: got writes=%0d overflow=%b, required 20 0", write_count - wc0, overflow);
        end
    endtask

    task automatic test_frame_end();
        int wc0 = write_count;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    fb.fb_wr_ready = ~fb.fb_wr_ready;
                end
                fb.fb_wr_ready = 1'b1;
            end
            begin
                int   budget = 60;
                send_pixel(10, 20, 8'h11, 1'b1, 1'b0);
                send_pixel(11, 20, 8'h22, 1'b1, 1'b0);
                send_pixel(12, 20, 8'h33, 1'b1, 1'b1);
                while (swap_pulse !== 1'b1 && budget > 0) begin
                    @(negedge clk);
                    budget--;
                end
                checks++;
                if (budget == 0 || sb.size() != 0 || write_count - wc0 != 3 || front_buffer !== 1'b1) begin
                    failures++;
                    $display("FAIL fe_swap: got pulse_seen=%0d pending=%0d writes=%0d front=%b, required 1 0 3 1",
                             budget != 0, sb.size(), write_count - wc0, front_buffer);
                end
                @(negedge clk);
                checks++;
                if (swap_pulse !== 1'b0 || front_buffer !== 1'b1) begin
                    failures++;
                    $display("FAIL fe_pulse_width: got swap=%b front=%b, required 0 1", swap_pulse, front_buffer);
                end
            end
        join
        model_front = 1'b1;
        send_pixel(0, 0, 8'h77, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (fb.fb_wr_valid !== 1'b1 || fb.fb_wr_addr !== 18'd0 || fb.fb_wr_data !== 8'h77) begin
            failures++;
            $display("FAIL fe_next_pixel: got valid=%b addr=%0d data=%h, required 1 0 77",
                     fb.fb_wr_valid, fb.fb_wr_addr, fb.fb_wr_data);
        end
        wait_idle("fe");
    endtask

    task automatic test_reset_mid();
        int   sc0   = swap_count;
        logic quiet = 1'b1;
        fb.fb_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_pixel(40 + i, 1, 8'(8'hC0 + i), 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        pix.frame_end = 1'b1;
        @(negedge clk);
        pix.frame_end = 1'b0;
        checks++;
        if (busy !== 1'b1 || pix.pixel_ready !== 1'b0 || fb.fb_wr_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: got busy=%b ready=%b valid=%b, required 1 0 1",
                     busy, pix.pixel_ready, fb.fb_wr_valid);
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if (fb.fb_wr_valid !== 1'b0 || busy !== 1'b0 || clipped_count !== 16'd0 ||
            front_buffer !== 1'b0 || overflow !== 1'b0 || swap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got valid=%b busy=%b clipped=%0d front=%b overflow=%b swap=%b, required all 0",
                     fb.fb_wr_valid, busy, clipped_count, front_buffer, overflow, swap_pulse);
        end
        sb.delete();
        model_front = 1'b0;
        @(negedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        fb.fb_wr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (swap_pulse !== 1'b0 || front_buffer !== 1'b0 || fb.fb_wr_valid !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (quiet !== 1'b1 || swap_count != sc0) begin
            failures++;
            $display("FAIL rst_no_swap: got activity after reset (swaps=%0d), required none", swap_count - sc0);
        end
    endtask

    task automatic test_double_swap();
        int sc0 = swap_count;
        pix.frame_end = 1'b1;
        @(negedge clk);
        pix.frame_end = 1'b0;
        checks++;
        if (pix.pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL ds_drain_ready: got pixel_ready=%b, required 0", pix.pixel_ready);
        end
        pix.frame_end = 1'b1;   // arrives while draining
        @(negedge clk);
        pix.frame_end = 1'b0;
        @(negedge clk);
        checks++;
        if (swap_pulse !== 1'b1 || front_buffer !== 1'b1 || pix.pixel_ready !== 1'b1) begin
            failures++;
            $display("FAIL ds_first_swap: got swap=%b front=%b ready=%b, required 1 1 1",
                     swap_pulse, front_buffer, pix.pixel_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (swap_count - sc0 != 2 || front_buffer !== 1'b0) begin
            failures++;
            $display("FAIL ds_total: got swaps=%0d front=%b, required 2 0", swap_count - sc0, front_buffer);
        end
        model_front = 1'b0;
    endtask

    task automatic test_overflow();
        int wc0 = write_count;
        pix.frame_end = 1'b1;
        @(negedge clk);
        pix.frame_end = 1'b0;
        // Deliberately ignore ready: pixel offered during DRAIN
        pix.pixel_valid = 1'b1;
        pix.pixel_x     = 11'd1;
        pix.pixel_y     = 11'd1;
        pix.pixel_draw  = 1'b1;
        pix.pixel_color = 8'hEE;
        @(negedge clk);
        pix.pixel_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got overflow=%b, required 1", overflow);
        end
        wait_idle("ovf");
        checks++;
        if (overflow !== 1'b1 || front_buffer !== 1'b1 || write_count != wc0) begin
            failures++;
            $display("FAIL ovf_after: got overflow=%b front=%b writes=%0d, required 1 1 0",
                     overflow, front_buffer, write_count - wc0);
        end
        model_front = 1'b1;
        send_pixel(2, 2, 8'h5A, 1'b1, 1'b0);
        wait_idle("ovf_next");
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_clip();
        test_backpressure();
        test_frame_end();
        test_reset_mid();
        test_double_swap();
        test_overflow();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL final_scoreboard: got %0d outstanding writes, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Pixel sink stage directly downstream of the rasterizer output stream (color, valid, x, y, draw, frame_end). Clips and linearises each pixel into a double-buffered 8-bit framebuffer address and buffers writes in a small FIFO toward a stallable memory write port. On `frame_end` it drains all pending writes, then swaps front and back buffers with a one-cycle pulse.

## Interface
- `FB_WIDTH`, 320: visible pixels per line.
- `FB_HEIGHT`, 240: visible lines.
- `FIFO_DEPTH`, 16: write FIFO entries, power of two, ≥4.
- `ADDR_W`, 18: framebuffer address width, ≥ clog2(2·FB_WIDTH·FB_HEIGHT).
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `pixel_color` in 8: pixel value.
- `pixel_valid` in 1: pixel present.
- `pixel_x` in 11: unsigned column.
- `pixel_y` in 11: unsigned row.
- `pixel_draw` in 1: 1 = write pixel, 0 = discard silently.
- `frame_end` in 1: single-cycle end-of-frame marker.
- `pixel_ready` out 1: accept handshake for the pixel stream.
- `fb_wr_addr` out ADDR_W: framebuffer write address.
- `fb_wr_data` out 8: framebuffer write data.
- `fb_wr_valid` out 1: write request.
- `fb_wr_ready` in 1: memory accepts the write.
- `front_buffer` out 1: buffer index currently displayed (0 = lower half, 1 = upper half).
- `swap_pulse` out 1: one cycle, asserted when `front_buffer` toggles.
- `busy` out 1: high whenever S1 or the FIFO holds data, or the FSM is not in RUN.
- `clipped_count` out 16: saturating count of drawn pixels that were off-screen.
- `overflow` out 1: sticky flag; `pixel_valid` was seen while `pixel_ready`=0.

## Operation
- Accept: `pixel_valid & pixel_ready`.
- Keep condition: `pixel_draw=1`, `x<FB_WIDTH` and `y<FB_HEIGHT`.
  - `pixel_draw=0`: drop the pixel, no count.
  - Drawn but out of range: drop the pixel and increment `clipped_count`, saturating at 0xFFFF.
- Address: `addr = (~front_buffer ? FB_WIDTH·FB_HEIGHT : 0) + y·FB_WIDTH + x`, computed at full width then truncated to ADDR_W.
- Pipeline:
  - Stage S1 registers addr, data and keep.
  - S1 pushes into the FIFO when keep=1.
- FIFO:
  - First-word-fall-through; the head drives `fb_wr_*`.
  - Pop on `fb_wr_valid & fb_wr_ready`.
  - Push and pop in the same cycle leaves the count unchanged.
- `pixel_ready = (state==RUN) & (fifo_count + s1_valid < FIFO_DEPTH)`. This guarantees S1 never stalls and the FIFO never overflows.
- Pixels presented while not ready are dropped and set `overflow`; the FIFO is never corrupted.
- FSM states:
  - RUN: normal acceptance. `frame_end`, or a latched pending end, moves to DRAIN.
  - DRAIN: `pixel_ready`=0. Waits for S1 empty and FIFO empty, then moves to SWAP.
  - SWAP: toggles `front_buffer`, asserts `swap_pulse`, returns to RUN.
- `frame_end` in RUN together with an accepted pixel: the pixel belongs to the ending frame and is drained before the swap.
- `frame_end` in DRAIN or SWAP: latched into a one-bit pending flag. Repeated events collapse into that one flag. The flag is serviced on the first RUN cycle, which immediately enters DRAIN again.
- `fb_wr_valid` must stay asserted with stable addr and data until `fb_wr_ready`.
- Reset values:
  - State RUN, FIFO and S1 emptied; in-flight writes are lost.
  - `pixel_ready`=1 the first cycle after reset deasserts.
  - `fb_wr_valid`=0, `fb_wr_addr`=0, `fb_wr_data`=0.
  - `front_buffer`=0, `swap_pulse`=0, `busy`=0, `clipped_count`=0, `overflow`=0, pending=0.
  - Reset asserted mid-frame or mid-drain takes effect immediately; no swap occurs.

## Timing
- Pixel accepted at cycle T, FIFO empty: `fb_wr_valid`=1 with its address at T+2.
  - T+1: S1.
  - T+2: FIFO head.
- Sustained throughput is one pixel per cycle while `fb_wr_ready`=1.
- `frame_end` at T with an empty pipeline:
  - T+1: DRAIN, `pixel_ready`=0.
  - T+2: SWAP.
  - T+3: `swap_pulse`=1 and `front_buffer` toggled, both registered.
  - T+3: RUN, `pixel_ready`=1 again.
- Drain length with data present: the cycles needed to empty S1 and the FIFO, plus 2.
- `busy` is registered-equivalent: it is derived from state and occupancy with no combinational path from the pixel inputs.

## Test plan
- Reset, then pixel (x=3, y=2, color=0xA5, draw=1) with `fb_wr_ready`=1 → at T+2 expect `fb_wr_addr` = 76800+643 = 77443, data 0xA5, one-cycle valid.
- Pixels x=320,y=0 and x=0,y=240 with draw=1, plus x=5,y=5 with draw=0 → no writes; `clipped_count`=2.
- `fb_wr_ready`=0 while 20 consecutive valid pixels are offered:
  - `pixel_ready` falls once the FIFO holds 16 entries; `overflow` stays 0 if the source honours ready.
  - Releasing ready then yields 16 writes in order, and the remaining 4 are accepted after that.
- `frame_end` coincident with the last of 3 pixels, `fb_wr_ready` toggling → all 3 written to the upper half, then `swap_pulse` for one cycle, `front_buffer`=1. The next pixel (0,0) writes address 0.
- `frame_end` during DRAIN → exactly two swaps total; `front_buffer` returns to 0.
- Reset asserted with 5 FIFO entries pending → `fb_wr_valid` drops asynchronously, no swap, all counters zero.
